// File: rtl/mul_handshake_seq.sv
// ---------------------------------------------------------------------------
// mul_handshake_seq
// Front-end sequencer for the multiplicador core. It accepts one operand pair
// over a valid/ready handshake, launches the core with a one-cycle start
// pulse, and waits for Fin. It then registers the 2*SIZE-bit product and
// offers it downstream over a second valid/ready handshake. A watchdog
// reports an error result if Fin never arrives within TIMEOUT WAIT cycles.
// One transaction is in flight at a time. in_ready and busy are registered
// copies of the state decode and are updated together with the state.
// ---------------------------------------------------------------------------
module mul_handshake_seq #(
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 2 * SIZE + 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_a,
    input  logic [SIZE-1:0]     in_b,
    output logic [SIZE-1:0]     mul_a,
    output logic [SIZE-1:0]     mul_b,
    output logic                mul_start,
    input  logic                mul_fin,
    input  logic [2*SIZE-1:0]   mul_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_result,
    output logic                out_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    count_r;
    logic [SIZE-1:0]     mul_a_r;
    logic [SIZE-1:0]     mul_b_r;
    logic                mul_start_r;
    logic                out_valid_r;
    logic [2*SIZE-1:0]   out_result_r;
    logic                out_err_r;
    logic                in_ready_r;
    logic                busy_r;

    // A Fin seen while the count is still zero belongs to the previous
    // operation (the core has not yet reacted to the new start), so it is
    // ignored.
    function automatic logic fin_accepted(input logic fin, input logic [CNT_W-1:0] cnt);
        return fin && (cnt != CNT_ZERO);
    endfunction

    // The watchdog fires on the last permitted WAIT cycle.
    function automatic logic watchdog_expired(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_LAST;
    endfunction

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= CNT_ZERO;
            mul_a_r      <= {SIZE{1'b0}};
            mul_b_r      <= {SIZE{1'b0}};
            mul_start_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {(2*SIZE){1'b0}};
            out_err_r    <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a_r     <= in_a;
                        mul_b_r     <= in_b;
                        mul_start_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_START;
                    end else begin
                        mul_start_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                ST_START: begin
                    mul_start_r <= 1'b0;
                    count_r     <= CNT_ZERO;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    count_r <= count_r + CNT_ONE;
                    if (fin_accepted(mul_fin, count_r)) begin
                        // Fin takes priority over a coincident timeout.
                        out_result_r <= mul_result;
                        out_err_r    <= 1'b0;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_HOLD;
                    end else if (watchdog_expired(count_r)) begin
                        out_result_r <= {(2*SIZE){1'b0}};
                        out_err_r    <= 1'b1;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_HOLD;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        // out_result deliberately keeps the delivered value.
                        out_valid_r <= 1'b0;
                        out_err_r   <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= CNT_ZERO;
                    mul_start_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_err_r   <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a      = mul_a_r;
    assign mul_b      = mul_b_r;
    assign mul_start  = mul_start_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_err    = out_err_r;
    assign in_ready   = in_ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mul_handshake_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mul_handshake_seq (SIZE=4, TIMEOUT=12).
// A behavioural multiplicador core answers mul_start after a programmable
// number of cycles and holds Fin until the next start. Expected product,
// error flag and accept-to-out_valid latency come from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mul_handshake_seq;

    localparam int SIZE    = 4;
    localparam int TIMEOUT = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [SIZE-1:0]     in_a = 4'h0;
    logic [SIZE-1:0]     in_b = 4'h0;
    logic [SIZE-1:0]     mul_a;
    logic [SIZE-1:0]     mul_b;
    logic                mul_start;
    logic                mul_fin;
    logic [2*SIZE-1:0]   mul_result;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [2*SIZE-1:0]   out_result;
    logic                out_err;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    // core model state
    int                core_lat = 0;
    int                core_cnt = 0;
    logic              core_busy = 1'b0;
    logic              core_fin = 1'b0;
    logic [7:0]        core_res = 8'h00;
    logic              force_en = 1'b0;
    logic              force_val = 1'b0;

    always #5 clk = ~clk;

    mul_handshake_seq #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_fin    (mul_fin),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 8'(sa * sb);
    endfunction

    // Accept-to-out_valid cycles for a core answering L cycles after start:
    // Fin is visible from WAIT cycle L+2, the watchdog ends WAIT cycle 12.
    function automatic int ref_lat(input int l);
        return (l + 2 <= TIMEOUT) ? l + 3 : TIMEOUT + 1;
    endfunction

    assign mul_fin    = force_en ? force_val : core_fin;
    assign mul_result = core_res;

    // Behavioural core: restart on mul_start, raise Fin after core_lat cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_fin  <= 1'b0;
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_res  <= 8'h00;
        end else if (mul_start) begin
            core_fin  <= 1'b0;
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            core_res  <= ref_prod(mul_a, mul_b);
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_fin  <= 1'b1;
                core_busy <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Launch-pulse counter.
    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // One full transaction. rel_at>=0 forces Fin high until that cycle;
    // f0 ties Fin low; hold>0 stalls the consumer and pokes in_valid.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int lat,
                           input int hold, input int rel_at, input bit f0,
                           input logic [7:0] exp_res, input bit exp_err,
                           input int exp_lat, input string nm);
        int  c;
        int  s0;
        bit  got;
        in_a     = a;
        in_b     = b;
        core_lat = lat;
        if (f0) begin
            force_en = 1'b1; force_val = 1'b0;
        end else if (rel_at >= 0) begin
            force_en = 1'b1; force_val = 1'b1;
        end else begin
            force_en = 1'b0;
        end
        check({nm, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        s0 = start_cnt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 0;
        got = 1'b0;
        check({nm, ".mul_start"}, mul_start, 1);
        check({nm, ".mul_a"}, mul_a, a);
        check({nm, ".mul_b"}, mul_b, b);
        while (!got && c < 40) begin
            if (rel_at >= 0 && c == rel_at) force_en = 1'b0;
            if (hold > 0) begin
                in_valid = 1'b1; in_a = ~a; in_b = ~b;
            end
            @(posedge clk); #1;
            c++;
            if (out_valid) got = 1'b1;
        end
        check({nm, ".out_valid_seen"}, got, 1);
        check({nm, ".latency"}, c, exp_lat);
        check({nm, ".out_result"}, out_result, exp_res);
        check({nm, ".out_err"}, out_err, exp_err);
        check({nm, ".start_pulses"}, start_cnt - s0, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({nm, ".hold_valid"}, out_valid, 1);
            check({nm, ".hold_result"}, out_result, exp_res);
            check({nm, ".hold_err"}, out_err, exp_err);
            check({nm, ".hold_in_ready"}, in_ready, 0);
            check({nm, ".hold_mul_a"}, mul_a, a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        force_en  = 1'b0;
        check({nm, ".done_valid"}, out_valid, 0);
        check({nm, ".done_err"}, out_err, 0);
        check({nm, ".done_in_ready"}, in_ready, 1);
        check({nm, ".done_busy"}, busy, 0);
        check({nm, ".done_result_kept"}, out_result, exp_res);
        check({nm, ".no_extra_start"}, start_cnt - s0, 1);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        int         hold;
        logic [7:0] res;
        bit         err;
        int         cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        int         rl;
        int         rh;

        vecs[0] = '{4'h3, 4'h5, 0,  0, 8'h0F, 1'b0, 3};
        vecs[1] = '{4'hD, 4'h2, 0,  0, 8'hFA, 1'b0, 3};
        vecs[2] = '{4'h8, 4'h8, 2,  0, 8'h40, 1'b0, 5};
        vecs[3] = '{4'h3, 4'h5, 0,  5, 8'h0F, 1'b0, 3};
        vecs[4] = '{4'h7, 4'h7, 10, 0, 8'h31, 1'b0, 13};
        vecs[5] = '{4'h1, 4'h1, 11, 0, 8'h00, 1'b1, 13};
        vecs[6] = '{4'hF, 4'hF, 1,  0, 8'h01, 1'b0, 4};
        vecs[7] = '{4'h7, 4'h8, 4,  2, 8'hC8, 1'b0, 7};

        // reset state
        #12;
        check("rst.mul_a", mul_a, 0);
        check("rst.mul_b", mul_b, 0);
        check("rst.out_result", out_result, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_err", out_err, 0);
        check("rst.mul_start", mul_start, 0);
        check("rst.busy", busy, 0);
        check("rst.in_ready", in_ready, 1);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold, -1, 1'b0,
                    vecs[i].res, vecs[i].err, vecs[i].cyc, $sformatf("vec%0d", i));
        end

        // Fin tied low: watchdog result
        run_txn(4'h2, 4'h3, 0, 0, -1, 1'b1, 8'h00, 1'b1, 13, "fin_tied0");
        // Fin held high throughout: masked in WAIT1, captured in WAIT2
        run_txn(4'h2, 4'h3, 0, 0, 100, 1'b0, 8'h06, 1'b0, 3, "fin_stale_held");
        // Fin high only through WAIT1: not captured, real Fin arrives later
        run_txn(4'h3, 4'h3, 3, 0, 2, 1'b0, 8'h09, 1'b0, 6, "fin_stale_drop");

        // asynchronous reset in the middle of WAIT
        in_a = 4'h5; in_b = 4'h3; core_lat = 5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst.busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.out_err", out_err, 0);
        check("midrst.out_result", out_result, 0);
        check("midrst.mul_start", mul_start, 0);
        check("midrst.mul_a", mul_a, 0);
        check("midrst.mul_b", mul_b, 0);
        check("midrst.busy", busy, 0);
        #10;
        reset = 1'b1;
        @(posedge clk); #1;
        run_txn(4'h7, 4'h7, 0, 0, -1, 1'b0, 8'h31, 1'b0, 3, "after_rst");

        // randomized transactions against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rl = $urandom_range(0, 12);
            rh = $urandom_range(0, 3);
            run_txn(ra, rb, rl, rh, -1, 1'b0,
                    (rl + 2 <= TIMEOUT) ? ref_prod(ra, rb) : 8'h00,
                    (rl + 2 > TIMEOUT), ref_lat(rl), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
